// File: rtl/operand_fetch_if.sv
// Bundle between the operand fetch sequencer and its environment.
// It carries the control unit handshake, the register bank read port and the temp register write side.
interface operand_fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              start;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic              load_en;
   logic              rf_re;
   logic [ADDR_W-1:0] rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              load_temp;
   logic [DATA_W-1:0] temp_data;
   logic              busy;
   logic              done;

   modport master (
      input  start, addr_a, addr_b, load_en, rf_rdata,
      output rf_re, rf_raddr, op_a, op_b, load_temp, temp_data, busy, done
   );

   modport slave (
      output start, addr_a, addr_b, load_en, rf_rdata,
      input  rf_re, rf_raddr, op_a, op_b, load_temp, temp_data, busy, done
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads two operands from the register bank, holds them for the ALU,
// and can optionally strobe operand A into the temp register.
module operand_fetch #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input logic clk,
   input logic reset,
   operand_fetch_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ_A,
      CAP_A,
      CAP_B,
      LOAD,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [ADDR_W-1:0] addr_a_q;
   logic [ADDR_W-1:0] addr_b_q;
   logic              load_en_q;
   logic              same_addr;

   logic [DATA_W-1:0] op_a_q;
   logic [DATA_W-1:0] op_b_q;
   logic [DATA_W-1:0] temp_q;

   logic              rf_re_q;
   logic              rf_re_d;
   logic [ADDR_W-1:0] rf_raddr_q;
   logic [ADDR_W-1:0] rf_raddr_d;
   logic              load_temp_q;
   logic              load_temp_d;
   logic              busy_q;
   logic              busy_d;
   logic              done_q;
   logic              done_d;

   assign same_addr = (addr_a_q == addr_b_q);

   // Next state plus the outputs that state will present. The outputs are decoded from next_state
   // so they can be registered and still line up with the state they belong to.
   // REQ_A is only entered from IDLE, so its address comes straight from the input being captured.
   always_comb begin
      next_state  = state;
      rf_re_d     = 1'b0;
      rf_raddr_d  = '0;
      load_temp_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;

      case (state)
         IDLE:    if (bus.start) next_state = REQ_A;
         REQ_A:   next_state = CAP_A;
         CAP_A:   begin
            if (!same_addr)     next_state = CAP_B;
            else if (load_en_q) next_state = LOAD;
            else                next_state = DONE;
         end
         CAP_B:   next_state = load_en_q ? LOAD : DONE;
         LOAD:    next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase

      busy_d = (next_state != IDLE);

      case (next_state)
         REQ_A: begin
            rf_re_d    = 1'b1;
            rf_raddr_d = bus.addr_a;
         end
         CAP_A: begin
            if (!same_addr) begin
               rf_re_d    = 1'b1;
               rf_raddr_d = addr_b_q;
            end
         end
         LOAD:    load_temp_d = 1'b1;
         DONE:    done_d      = 1'b1;
         default: ;
      endcase
   end

   // State and registered control outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rf_re_q     <= 1'b0;
         rf_raddr_q  <= '0;
         load_temp_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= next_state;
         rf_re_q     <= rf_re_d;
         rf_raddr_q  <= rf_raddr_d;
         load_temp_q <= load_temp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Request capture and operand datapath. When both addresses match, the single read
   // fills op_b as well, which is what removes the second read cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         load_en_q <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         temp_q    <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            addr_a_q  <= bus.addr_a;
            addr_b_q  <= bus.addr_b;
            load_en_q <= bus.load_en;
         end
         if (state == CAP_A) begin
            op_a_q <= bus.rf_rdata;
            temp_q <= bus.rf_rdata;
            if (same_addr) op_b_q <= bus.rf_rdata;
         end
         if (state == CAP_B) op_b_q <= bus.rf_rdata;
      end
   end

   assign bus.rf_re     = rf_re_q;
   assign bus.rf_raddr  = rf_raddr_q;
   assign bus.load_temp = load_temp_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;
   assign bus.temp_data = temp_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a transaction-level timing model is compared every cycle,
// and directed scenarios pin the model down with hand-computed latencies and data.
module tb_operand_fetch;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   operand_fetch_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register bank contents; unread cycles return a marker value so stale captures show up.
   logic [15:0] mem [8];
   initial begin
      mem[0] = 16'h5A5A; mem[1] = 16'h1234; mem[2] = 16'hABCD; mem[3] = 16'h00FF;
      mem[4] = 16'hBEEF; mem[5] = 16'hC0DE; mem[6] = 16'h0F0F; mem[7] = 16'hFFFF;
   end

   always @(posedge clk) begin
      if (bus.rf_re) bus.rf_rdata <= mem[bus.rf_raddr];
      else           bus.rf_rdata <= 16'hDEAD;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: k counts cycles since acceptance; a fetch lasts 3 cycles,
   // plus one for a second read and one for the temp load.
   bit          m_active;
   int          m_k;
   int          m_len;
   logic [2:0]  m_a;
   logic [2:0]  m_b;
   logic        m_le;
   logic [15:0] m_op_a;
   logic [15:0] m_op_b;
   logic [15:0] m_temp;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 0; m_k = 0; m_len = 0;
         m_a = 0; m_b = 0; m_le = 0;
         m_op_a = 0; m_op_b = 0; m_temp = 0;
      end else if (!m_active) begin
         if (bus.start) begin
            m_active = 1;
            m_k      = 1;
            m_a      = bus.addr_a;
            m_b      = bus.addr_b;
            m_le     = bus.load_en;
            m_len    = 3 + ((m_a != m_b) ? 1 : 0) + (m_le ? 1 : 0);
         end
      end else begin
         if (m_k == 2) begin
            m_op_a = mem[m_a];
            m_temp = mem[m_a];
            if (m_a == m_b) m_op_b = mem[m_a];
         end
         if (m_k == 3 && m_a != m_b) m_op_b = mem[m_b];
         m_k++;
         if (m_k > m_len) m_active = 0;
      end
   end

   always @(negedge clk) begin
      logic       exp_re;
      logic [2:0] exp_addr;
      exp_re   = m_active && (m_k == 1 || (m_k == 2 && m_a != m_b));
      exp_addr = !m_active ? 3'd0 : (m_k == 1) ? m_a : (m_k == 2 && m_a != m_b) ? m_b : 3'd0;
      checkOutput("busy",      32'(bus.busy),      32'(m_active));
      checkOutput("done",      32'(bus.done),      32'(m_active && m_k == m_len));
      checkOutput("load_temp", 32'(bus.load_temp), 32'(m_active && m_le && m_k == m_len - 1));
      checkOutput("rf_re",     32'(bus.rf_re),     32'(exp_re));
      checkOutput("rf_raddr",  32'(bus.rf_raddr),  32'(exp_addr));
      checkOutput("op_a",      32'(bus.op_a),      32'(m_op_a));
      checkOutput("op_b",      32'(bus.op_b),      32'(m_op_b));
      checkOutput("temp_data", 32'(bus.temp_data), 32'(m_temp));
   end

   int          doneCyc;
   int          doneCnt;
   int          loadCyc;
   int          loadCnt;
   int          reCnt;
   logic [2:0]  raddr1;
   logic [2:0]  raddr2;
   logic [15:0] tempAtLoad;

   // One fetch: start in cycle 0, then a fixed window of cycles with inputs scrambled so
   // late changes would be visible; optionally re-pulse start in cycles 2 and 3.
   task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic le,
                                input bit ignorePulses, input int window);
      @(posedge clk); #2;
      bus.start = 1'b1; bus.addr_a = a; bus.addr_b = b; bus.load_en = le;
      doneCyc = -1; doneCnt = 0; loadCyc = -1; loadCnt = 0; reCnt = 0;
      raddr1 = 0; raddr2 = 0; tempAtLoad = 0;
      for (int c = 1; c <= window; c++) begin
         @(posedge clk); #2;
         bus.start   = ignorePulses && (c == 2 || c == 3);
         bus.addr_a  = ~a;
         bus.addr_b  = ~b;
         bus.load_en = ~le;
         @(negedge clk);
         if (bus.rf_re) reCnt++;
         if (c == 1) raddr1 = bus.rf_raddr;
         if (c == 2) raddr2 = bus.rf_raddr;
         if (bus.load_temp) begin
            loadCnt++;
            if (loadCyc < 0) begin loadCyc = c; tempAtLoad = bus.temp_data; end
         end
         if (bus.done) begin
            doneCnt++;
            if (doneCyc < 0) doneCyc = c;
         end
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int dones[$];
      int busyLow;
      total = 0; bad = 0;
      reset = 1'b1;
      bus.start = 0; bus.addr_a = 0; bus.addr_b = 0; bus.load_en = 0;
      #12;
      checkOutput("reset_busy", 32'(bus.busy), 0);
      checkOutput("reset_op_a", 32'(bus.op_a), 0);
      checkOutput("reset_rf_re", 32'(bus.rf_re), 0);
      reset = 1'b0;

      // Distinct addresses with temp load.
      applyStimulus(3'd1, 3'd2, 1'b1, 0, 7);
      checkOutput("t1_raddr1", 32'(raddr1), 1);
      checkOutput("t1_raddr2", 32'(raddr2), 2);
      checkOutput("t1_re_cnt", 32'(reCnt), 2);
      checkOutput("t1_load_cyc", 32'(loadCyc), 4);
      checkOutput("t1_load_cnt", 32'(loadCnt), 1);
      checkOutput("t1_temp", 32'(tempAtLoad), 32'h1234);
      checkOutput("t1_done_cyc", 32'(doneCyc), 5);
      checkOutput("t1_done_cnt", 32'(doneCnt), 1);
      checkOutput("t1_op_a", 32'(bus.op_a), 32'h1234);
      checkOutput("t1_op_b", 32'(bus.op_b), 32'hABCD);

      // Same address: single read.
      applyStimulus(3'd3, 3'd3, 1'b1, 0, 6);
      checkOutput("t2_re_cnt", 32'(reCnt), 1);
      checkOutput("t2_load_cyc", 32'(loadCyc), 3);
      checkOutput("t2_done_cyc", 32'(doneCyc), 4);
      checkOutput("t2_op_a", 32'(bus.op_a), 32'h00FF);
      checkOutput("t2_op_b", 32'(bus.op_b), 32'h00FF);

      // No temp load.
      applyStimulus(3'd4, 3'd5, 1'b0, 0, 6);
      checkOutput("t3_load_cnt", 32'(loadCnt), 0);
      checkOutput("t3_done_cyc", 32'(doneCyc), 4);
      checkOutput("t3_temp", 32'(bus.temp_data), 32'hBEEF);
      checkOutput("t3_op_b", 32'(bus.op_b), 32'hC0DE);

      // Same address, no load: shortest path.
      applyStimulus(3'd7, 3'd7, 1'b0, 0, 5);
      checkOutput("t4_done_cyc", 32'(doneCyc), 3);
      checkOutput("t4_op_b", 32'(bus.op_b), 32'hFFFF);

      // Start pulses while busy are ignored.
      applyStimulus(3'd6, 3'd0, 1'b1, 1, 9);
      checkOutput("t5_done_cnt", 32'(doneCnt), 1);
      checkOutput("t5_done_cyc", 32'(doneCyc), 5);
      checkOutput("t5_re_cnt", 32'(reCnt), 2);
      checkOutput("t5_op_a", 32'(bus.op_a), 32'h0F0F);
      checkOutput("t5_op_b", 32'(bus.op_b), 32'h5A5A);

      // Asynchronous reset in the middle of CAP_B.
      @(posedge clk); #2;
      bus.start = 1; bus.addr_a = 3'd1; bus.addr_b = 3'd2; bus.load_en = 1;
      @(posedge clk); #2; bus.start = 0;
      @(posedge clk); #2;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_done", 32'(bus.done), 0);
      checkOutput("rst_load_temp", 32'(bus.load_temp), 0);
      checkOutput("rst_rf_re", 32'(bus.rf_re), 0);
      checkOutput("rst_rf_raddr", 32'(bus.rf_raddr), 0);
      checkOutput("rst_op_a", 32'(bus.op_a), 0);
      checkOutput("rst_op_b", 32'(bus.op_b), 0);
      checkOutput("rst_temp", 32'(bus.temp_data), 0);
      @(posedge clk); #2;
      reset = 1'b0;
      loadCnt = 0; doneCnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.load_temp) loadCnt++;
         if (bus.done) doneCnt++;
      end
      checkOutput("rst_no_load", 32'(loadCnt), 0);
      checkOutput("rst_no_done", 32'(doneCnt), 0);
      applyStimulus(3'd1, 3'd2, 1'b1, 0, 7);
      checkOutput("post_rst_done_cyc", 32'(doneCyc), 5);
      checkOutput("post_rst_op_b", 32'(bus.op_b), 32'hABCD);

      // Start held high for 20 cycles.
      @(posedge clk); #2;
      bus.start = 1; bus.addr_a = 3'd2; bus.addr_b = 3'd5; bus.load_en = 1;
      busyLow = 0;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk); #2;
         bus.start = (c < 20);
         @(negedge clk);
         if (bus.done) dones.push_back(c);
         if (c <= 23 && !bus.busy) busyLow++;
      end
      bus.start = 0;
      checkOutput("hold_done_cnt", 32'(dones.size()), 4);
      if (dones.size() > 0) checkOutput("hold_first_done", 32'(dones[0]), 5);
      for (int i = 1; i < dones.size(); i++)
         checkOutput("hold_period", 32'(dones[i] - dones[i-1]), 6);
      checkOutput("hold_busy_low", 32'(busyLow), 3);
      checkOutput("hold_op_b", 32'(bus.op_b), 32'hC0DE);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Initiator-side sequencer for the 16-bit datapath.
- Reads two operands from the register bank over its 1-cycle-latency read port and holds them as op_a/op_b for the ALU.
- Then drives the temp register's write side: a one-cycle load_temp strobe with temp_data = op_a.
- Sits between the control unit (start/done handshake) and the register bank / temp register.

Parameters:
- DATA_W, 16, operand and temp data width.
- ADDR_W, 3, register bank address width (8 registers).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request a fetch; sampled only in IDLE.
- addr_a  in  ADDR_W  register index of operand A; captured on accepted start.
- addr_b  in  ADDR_W  register index of operand B; captured on accepted start.
- load_en  in  1  captured on accepted start; 1 = issue load_temp after fetch.
- rf_re  out  1  register bank read enable.
- rf_raddr  out  ADDR_W  register bank read address.
- rf_rdata  in  DATA_W  register bank read data, valid the cycle after rf_re.
- op_a  out  DATA_W  fetched operand A (registered).
- op_b  out  DATA_W  fetched operand B (registered).
- load_temp  out  1  one-cycle write strobe to the temp register.
- temp_data  out  DATA_W  data for the temp register (registered copy of op_a).
- busy  out  1  high from the cycle after start acceptance until DONE is left.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0: op_a, op_b, temp_data, rf_raddr, rf_re, load_temp, busy, done.
  - Captured addresses and load_en flag cleared.
  - A fetch in progress is abandoned; no load_temp or done pulse is issued for it.
- Outputs are registered, Moore-style per state. rf_re, rf_raddr, load_temp and done are 0 in any state that does not assert them.
- IDLE:
  - busy=0.
  - On start=1: capture addr_a, addr_b, load_en; go to REQ_A.
- REQ_A: rf_re=1, rf_raddr=addr_a_q; go to CAP_A.
- CAP_A: at the edge, op_a<=rf_rdata and temp_data<=rf_rdata.
  - If addr_a_q != addr_b_q: rf_re=1, rf_raddr=addr_b_q; go to CAP_B.
  - If addr_a_q == addr_b_q: no second read; op_b<=rf_rdata at the same edge; go to LOAD if load_en_q, else DONE.
- CAP_B: at the edge, op_b<=rf_rdata; go to LOAD if load_en_q, else DONE.
- LOAD: load_temp=1 for exactly one cycle, with temp_data=op_a stable; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
  - busy is still 1 in DONE and 0 from the next cycle.
- Latency, counted from the cycle start is sampled (cycle 0):
  - Distinct addresses, load_en=1: done in cycle 5.
  - Distinct addresses, load_en=0: done in cycle 4.
  - Same address, load_en=1: done in cycle 4.
  - Same address, load_en=0: done in cycle 3.
- start while busy=1 (states other than IDLE) is ignored. It is not queued.
- start held high continuously: a new fetch is accepted in the IDLE cycle after DONE. Back-to-back fetch period is 6 cycles for the full path (one IDLE cycle between fetches).
- addr_a, addr_b and load_en changes after acceptance have no effect on the fetch in progress.
- op_a, op_b and temp_data hold their last values between fetches. They are overwritten only in CAP_A/CAP_B.
- No arithmetic; all data paths are DATA_W wide, with no truncation or extension.

Test Plan:
- Reset, then start with addr_a=1, addr_b=2, load_en=1; bank holds R1=16'h1234, R2=16'hABCD.
  - rf_raddr=1 in cycle 1 and =2 in cycle 2, each with rf_re=1.
  - op_a=16'h1234, op_b=16'hABCD.
  - load_temp=1 in cycle 4 only, with temp_data=16'h1234.
  - done=1 in cycle 5 only.
- start with addr_a=addr_b=3, R3=16'h00FF, load_en=1.
  - Exactly one rf_re cycle.
  - op_a=op_b=16'h00FF.
  - load_temp in cycle 3, done in cycle 4.
- start with load_en=0, addr_a=4, addr_b=5.
  - load_temp never asserted.
  - done in cycle 4.
  - temp_data still updates to R4.
- Pulse start again in cycles 2 and 3 of an active fetch.
  - Ignored: exactly one done pulse.
  - No extra rf_re after CAP_B.
- Assert reset asynchronously mid-CAP_B (between clock edges).
  - All outputs 0 immediately; no load_temp or done follows.
  - A new start after reset release completes normally.
- Hold start=1 for 20 cycles with distinct addresses and load_en=1.
  - done pulses every 6 cycles.
  - busy=0 for exactly one cycle between fetches.
